host_bus_initiator: RTL and testbench

//  Bus-master counterpart of the FPGA memory-cycle responder: runs TMS9900-style

---
 rtl/host_bus_initiator.sv | 223 ++++++++++++++++++++++
 tb/tb_host_bus_initiator.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_bus_initiator.sv
// Host 4A bus master: shifts the word address into two 74HC595 lanes, then runs two byte cycles.
// Optional host READY wait-state input is enabled by defining HOST_BUS_READY_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE  0  | waiting for a request, req_ready high
// SHIFT 1  | address bits serialised on both lanes, MSB of each lane first
// LATCH 2  | rclk pulse into the 595 storage registers, then one settle clk
// HI_BYTE 3| byte cycle with a15=0 (word bits 15:8)
// LO_BYTE 4| byte cycle with a15=1 (word bits 7:0)
// DONE  5  | bus released, rsp_valid pulse
module host_bus_initiator #(
   parameter int CLK_DIV     = 2,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [15:0] req_addr,
   input  logic        req_write,
   input  logic [15:0] req_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        o_sdo1,
   output logic        o_sdo2,
   output logic        o_serclk,
   output logic        o_rclk,
   output logic        o_memen,
   output logic        o_dbin,
   output logic        o_we,
   output logic        o_a15,
   output logic [7:0]  o_data_bus,
   output logic        o_data_oe,
   input  logic [7:0]  i_data_bus,
`ifdef HOST_BUS_READY_EN
   input  logic        i_ready,
`endif
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SHIFT = 3'd1,
      S_LATCH = 3'd2,
      S_HI    = 3'd3,
      S_LO    = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      PH_SETUP  = 2'd0,
      PH_STROBE = 2'd1,
      PH_HOLD   = 2'd2
   } phase_t;

   localparam logic [15:0] DIV_LOAD  = 16'(CLK_DIV - 1);
   localparam logic [15:0] WAIT_LOAD = 16'(WAIT_CYCLES - 1);

   state_t       state_q, state_d;
   phase_t       byte_ph;
   logic [15:1]  addr_q;
   logic         write_q;
   logic [15:0]  wdata_q;
   logic [15:0]  rd_buf;
   logic [15:0]  rsp_rdata_q;
   logic [15:0]  div_cnt;
   logic [15:0]  cnt;
   logic [2:0]   bit_idx;
   logic         ser_hi;
   logic         ready_ok;
   logic [7:0]   lane1, lane2;
   logic         in_byte;
   logic         unused_addr0;

   assign unused_addr0 = req_addr[0];

`ifdef HOST_BUS_READY_EN
   logic [1:0] rdy_sync;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rdy_sync <= 2'b00;
      else          rdy_sync <= {rdy_sync[0], i_ready};
   end

   assign ready_ok = rdy_sync[1];
`else
   assign ready_ok = 1'b1;
`endif

   // TI numbering: An is word-address bit 15-n; A15 (byte select) always shifted as 0.
   assign lane1 = {addr_q[6], addr_q[13], addr_q[9], addr_q[14],
                   addr_q[15], 1'b0, addr_q[8], addr_q[7]};
   assign lane2 = {addr_q[10], addr_q[11], addr_q[3], addr_q[1],
                   addr_q[2], addr_q[12], addr_q[4], addr_q[5]};

   assign in_byte = (state_q == S_HI) || (state_q == S_LO);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (req_valid) state_d = S_SHIFT;
         S_SHIFT: if (div_cnt == 16'd0 && ser_hi && bit_idx == 3'd7) state_d = S_LATCH;
         S_LATCH: if (cnt == 16'd0) state_d = S_HI;
         S_HI:    if (byte_ph == PH_HOLD) state_d = S_LO;
         S_LO:    if (byte_ph == PH_HOLD) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q      <= '0;
         write_q     <= 1'b0;
         wdata_q     <= '0;
         rd_buf      <= '0;
         rsp_rdata_q <= '0;
         div_cnt     <= '0;
         cnt         <= '0;
         bit_idx     <= '0;
         ser_hi      <= 1'b0;
         byte_ph     <= PH_SETUP;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  addr_q  <= req_addr[15:1];
                  write_q <= req_write;
                  wdata_q <= req_wdata;
               end
               div_cnt <= DIV_LOAD;
               bit_idx <= '0;
               ser_hi  <= 1'b0;
            end
            S_SHIFT: begin
               cnt <= 16'd1;
               if (div_cnt == 16'd0) begin
                  div_cnt <= DIV_LOAD;
                  ser_hi  <= !ser_hi;
                  if (ser_hi) bit_idx <= bit_idx + 3'd1;
               end else begin
                  div_cnt <= div_cnt - 16'd1;
               end
            end
            S_LATCH: begin
               if (cnt != 16'd0) cnt <= cnt - 16'd1;
               byte_ph <= PH_SETUP;
            end
            S_HI, S_LO: begin
               case (byte_ph)
                  PH_SETUP: begin
                     byte_ph <= PH_STROBE;
                     cnt     <= WAIT_LOAD;
                  end
                  PH_STROBE: begin
                     // minimum strobe first, then stretched while host READY is low
                     if (cnt != 16'd0) begin
                        cnt <= cnt - 16'd1;
                     end else if (ready_ok) begin
                        byte_ph <= PH_HOLD;
                        if (!write_q) begin
                           if (state_q == S_HI) rd_buf[15:8] <= i_data_bus;
                           else                 rd_buf[7:0]  <= i_data_bus;
                        end
                     end
                  end
                  default: begin
                     byte_ph <= PH_SETUP;
                     if (state_q == S_LO && !write_q) rsp_rdata_q <= rd_buf;
                  end
               endcase
            end
            default: begin
               byte_ph <= PH_SETUP;
            end
         endcase
      end
   end

   always_comb begin
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      o_sdo1     = 1'b0;
      o_sdo2     = 1'b0;
      o_serclk   = 1'b0;
      o_rclk     = 1'b0;
      o_memen    = 1'b1;
      o_dbin     = 1'b0;
      o_we       = 1'b1;
      o_a15      = 1'b0;
      o_data_bus = 8'h00;
      o_data_oe  = 1'b0;
      case (state_q)
         S_IDLE:  req_ready = 1'b1;
         S_SHIFT: begin
            o_sdo1   = lane1[3'd7 - bit_idx];
            o_sdo2   = lane2[3'd7 - bit_idx];
            o_serclk = ser_hi;
         end
         S_LATCH: o_rclk = (cnt != 16'd0);
         S_DONE:  rsp_valid = 1'b1;
         default: ;
      endcase
      if (in_byte) begin
         o_memen   = 1'b0;
         o_dbin    = !write_q;
         o_a15     = (state_q == S_LO);
         o_data_oe = write_q;
         o_we      = !(write_q && byte_ph == PH_STROBE);
         if (write_q) o_data_bus = (state_q == S_LO) ? wdata_q[7:0] : wdata_q[15:8];
      end
   end

   assign rsp_rdata = rsp_rdata_q;
   assign state     = state_q;

endmodule

// File: tb/tb_host_bus_initiator.sv
// Directed bench for host_bus_initiator: vector table plus reset, back-to-back and READY sequences.
// The READY wait-state sequence is compiled in when HOST_BUS_READY_EN is defined.
module tb_host_bus_initiator;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [15:0] req_addr = 16'h0000;
   logic        req_write = 1'b0;
   logic [15:0] req_wdata = 16'h0000;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        o_sdo1, o_sdo2, o_serclk, o_rclk, o_memen, o_dbin, o_we, o_a15, o_data_oe;
   logic [7:0]  o_data_bus;
   logic [7:0]  i_data_bus;
   logic [2:0]  state;
`ifdef HOST_BUS_READY_EN
   logic        i_ready = 1'b1;
`endif

   host_bus_initiator #(.CLK_DIV(2), .WAIT_CYCLES(2)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_write(req_write), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .o_sdo1(o_sdo1), .o_sdo2(o_sdo2), .o_serclk(o_serclk), .o_rclk(o_rclk),
      .o_memen(o_memen), .o_dbin(o_dbin), .o_we(o_we), .o_a15(o_a15),
      .o_data_bus(o_data_bus), .o_data_oe(o_data_oe), .i_data_bus(i_data_bus),
`ifdef HOST_BUS_READY_EN
      .i_ready(i_ready),
`endif
      .state(state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] addr;
      logic        wr;
      logic [15:0] wdata;
      logic [7:0]  bus_hi;
      logic [7:0]  bus_lo;
      logic [7:0]  lane1;
      logic [7:0]  lane2;
      logic [15:0] rdata;
   } vec_t;

   vec_t vecs [5];

   int checks = 0;
   int failures = 0;

   logic [7:0] cur_hi = 8'h00, cur_lo = 8'h00;

   // host memory model: byte chosen by a15; garbage while READY is held low
   always_comb begin
      i_data_bus = o_a15 ? cur_lo : cur_hi;
`ifdef HOST_BUS_READY_EN
      if (o_a15 && !i_ready) i_data_bus = 8'hEE;
`endif
   end

   logic [7:0] sh1 = 0, sh2 = 0, lat1 = 0, lat2 = 0;
   int ser_rises = 0, rclk_pulses = 0, we_cnt = 0, we_lo_cycles = 0, lo_cycles = 0, prot_viol = 0;
   logic [8:0] we_rec [2];
   logic saw_dbin = 0, saw_oe = 0;
   logic p_serclk = 0, p_sdo1 = 0, p_sdo2 = 0, p_rclk = 0, p_we = 1;

   always @(negedge clk) begin
      if (reset_n) begin
         if (o_serclk && !p_serclk) begin
            sh1 = {sh1[6:0], o_sdo1};
            sh2 = {sh2[6:0], o_sdo2};
            ser_rises++;
         end
         if (o_serclk && p_serclk && (o_sdo1 != p_sdo1 || o_sdo2 != p_sdo2)) prot_viol++;
         if (o_rclk && !p_rclk) begin
            lat1 = sh1;
            lat2 = sh2;
            rclk_pulses++;
         end
         if (!o_we) begin
            we_lo_cycles++;
            if (p_we) begin
               if (we_cnt < 2) we_rec[we_cnt] = {o_a15, o_data_bus};
               we_cnt++;
            end
         end
         if (!o_we && (o_memen || o_dbin)) prot_viol++;
         if (o_data_oe && o_dbin) prot_viol++;
         if (req_ready && state != 3'd0) prot_viol++;
         if (o_dbin) saw_dbin = 1'b1;
         if (o_data_oe) saw_oe = 1'b1;
         if (state == 3'd4) lo_cycles++;
      end
      p_serclk = o_serclk;
      p_sdo1   = o_sdo1;
      p_sdo2   = o_sdo2;
      p_rclk   = o_rclk;
      p_we     = o_we;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] outs_vec();
      return {26'd0, req_ready, rsp_valid, rsp_rdata, o_sdo1, o_sdo2, o_serclk, o_rclk,
              o_memen, o_dbin, o_we, o_a15, o_data_bus, o_data_oe, state};
   endfunction

   localparam logic [63:0] RST_OUTS = {26'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0,
                                       1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0};

   // lane contents in TI address-line names, first shifted bit ends up in bit 7
   function automatic logic [15:0] exp_lanes(input logic [15:0] a);
      int l1 [8];
      int l2 [8];
      logic [7:0] r1, r2;
      l1 = '{9, 2, 6, 1, 0, 15, 7, 8};
      l2 = '{5, 4, 12, 14, 13, 3, 11, 10};
      for (int i = 0; i < 8; i++) begin
         r1[7-i] = (l1[i] == 15) ? 1'b0 : a[15-l1[i]];
         r2[7-i] = (l2[i] == 15) ? 1'b0 : a[15-l2[i]];
      end
      return {r1, r2};
   endfunction

   task automatic start_req(input vec_t v);
      int t = 0;
      @(negedge clk);
      while (!req_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!req_ready) chk("req_ready_wait", {63'd0, req_ready}, 64'd1);
      cur_hi = v.bus_hi;
      cur_lo = v.bus_lo;
      sh1 = 0; sh2 = 0; lat1 = 0; lat2 = 0;
      ser_rises = 0; rclk_pulses = 0; we_cnt = 0; we_lo_cycles = 0; lo_cycles = 0;
      we_rec[0] = 0; we_rec[1] = 0; saw_dbin = 0; saw_oe = 0;
      req_addr = v.addr; req_write = v.wr; req_wdata = v.wdata; req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_addr = ~v.addr; req_wdata = ~v.wdata; req_write = ~v.wr;
   endtask

   task automatic run_txn(input vec_t v, input logic [15:0] exp_rdata, input int exp_lat,
                          input int exp_lo, input string tag);
      int n = 0;
      logic got = 1'b0;
      start_req(v);
      while (!got && n < 300) begin
         @(negedge clk);
         n++;
         if (rsp_valid) got = 1'b1;
      end
      chk({tag, ".latency"}, 64'(n - 1), 64'(exp_lat));
      chk({tag, ".rsp_rdata"}, {48'd0, rsp_rdata}, {48'd0, exp_rdata});
      chk({tag, ".busy_ready"}, {63'd0, req_ready}, 64'd0);
      chk({tag, ".lanes"}, {48'd0, lat1, lat2}, {48'd0, v.lane1, v.lane2});
      chk({tag, ".serclk_rises"}, 64'(ser_rises), 64'd8);
      chk({tag, ".rclk_pulses"}, 64'(rclk_pulses), 64'd1);
      chk({tag, ".lo_cycles"}, 64'(lo_cycles), 64'(exp_lo));
      chk({tag, ".we_pulses"}, 64'(we_cnt), v.wr ? 64'd2 : 64'd0);
      chk({tag, ".we_low_cycles"}, 64'(we_lo_cycles), v.wr ? 64'd4 : 64'd0);
      chk({tag, ".dbin_oe"}, {62'd0, saw_dbin, saw_oe}, v.wr ? 64'b01 : 64'b10);
      if (v.wr) begin
         chk({tag, ".we_hi_byte"}, {55'd0, we_rec[0]}, {55'd0, 1'b0, v.wdata[15:8]});
         chk({tag, ".we_lo_byte"}, {55'd0, we_rec[1]}, {55'd0, 1'b1, v.wdata[7:0]});
      end
      @(negedge clk);
      chk({tag, ".after_done"}, {46'd0, rsp_valid, req_ready, rsp_rdata},
          {46'd0, 1'b0, 1'b1, exp_rdata});
   endtask

   initial begin
      vec_t w;
      int n, accepts, rsps, rsp_seen;
      vecs[0] = '{16'h8300, 1'b1, 16'hBEEF, 8'h00, 8'h00, 8'h2A, 8'h00, 16'h0000};
      vecs[1] = '{16'h6000, 1'b0, 16'h0000, 8'h12, 8'h34, 8'h50, 8'h00, 16'h1234};
      vecs[2] = '{16'hFFFF, 1'b0, 16'h0000, 8'hA5, 8'h5A, 8'hFB, 8'hFF, 16'hA55A};
      vecs[3] = '{16'h0001, 1'b1, 16'h1234, 8'h00, 8'h00, 8'h00, 8'h00, 16'hA55A};
      vecs[4] = '{16'h0402, 1'b1, 16'h00FF, 8'h00, 8'h00, 8'h00, 8'h90, 16'hA55A};

      repeat (3) @(negedge clk);
      chk("reset_outputs", outs_vec(), RST_OUTS);
      reset_n = 1'b1;

      for (int i = 0; i < 5; i++)
         run_txn(vecs[i], vecs[i].rdata, 42, 4, $sformatf("vec%0d", i));

      // address-line walk: each word-address bit lands on exactly one lane position
      for (int k = 1; k < 16; k++) begin
         w = '{16'h0001 << k, 1'b0, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000};
         {w.lane1, w.lane2} = exp_lanes(w.addr);
         run_txn(w, 16'h0000, 42, 4, $sformatf("walk%0d", k));
         chk($sformatf("walk%0d.one_hot", k), 64'($countones({lat1, lat2})), 64'd1);
      end

      // reset in the middle of SHIFT
      start_req(vecs[0]);
      repeat (10) @(posedge clk);
      #1;
      chk("rst_shift.state_before", {61'd0, state}, 64'd1);
      #1 reset_n = 1'b0;
      #1 chk("rst_shift.outputs", outs_vec(), RST_OUTS);
      rsp_seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (rsp_valid) rsp_seen++;
      end
      chk("rst_shift.no_rsp", 64'(rsp_seen), 64'd0);
      reset_n = 1'b1;
      run_txn(vecs[1], 16'h1234, 42, 4, "post_rst_shift");

      // reset in the middle of HI_BYTE
      start_req(vecs[2]);
      n = 0;
      while (state != 3'd3 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("rst_hi.state_before", {61'd0, state}, 64'd3);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1 chk("rst_hi.outputs", outs_vec(), RST_OUTS);
      rsp_seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (rsp_valid) rsp_seen++;
      end
      chk("rst_hi.no_rsp", 64'(rsp_seen), 64'd0);
      reset_n = 1'b1;
      run_txn(vecs[4], 16'h0000, 42, 4, "post_rst_hi");

      // req_valid held high: one accept per completed cycle, 44 clks apart
      @(negedge clk);
      req_addr = 16'h2468; req_write = 1'b1; req_wdata = 16'h55AA; req_valid = 1'b1;
      accepts = 0;
      rsps = 0;
      for (int i = 0; i < 132; i++) begin
         if (req_valid && req_ready) accepts++;
         if (rsp_valid) rsps++;
         @(negedge clk);
      end
      req_valid = 1'b0;
      chk("held.accepts", 64'(accepts), 64'd3);
      chk("held.responses", 64'(rsps), 64'd3);

`ifdef HOST_BUS_READY_EN
      begin
         int ls;
         logic got;
         w = '{16'h6000, 1'b0, 16'h0000, 8'h12, 8'h56, 8'h50, 8'h00, 16'h1256};
         start_req(w);
         n = 0;
         ls = -1;
         got = 1'b0;
         while (!got && n < 300) begin
            @(negedge clk);
            n++;
            if (ls < 0 && state == 3'd4) begin
               i_ready = 1'b0;
               ls = n;
            end else if (ls >= 0 && n == ls + 5) begin
               i_ready = 1'b1;
            end
            if (rsp_valid) got = 1'b1;
         end
         i_ready = 1'b1;
         chk("ready.latency", 64'(n - 1), 64'd47);
         chk("ready.rsp_rdata", {48'd0, rsp_rdata}, 64'h1256);
         chk("ready.lo_cycles", 64'(lo_cycles), 64'd9);
         chk("ready.lanes", {48'd0, lat1, lat2}, 64'h5000);
      end
`endif

      chk("protocol_violations", 64'(prot_viol), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
